// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core: load-use interlock, branch
// redirect flushes, variable-latency data-memory stalls with timeout detection,
// Execute-stage operand forwarding and saturating stall/flush counters.
module hazard_unit #(
  parameter int unsigned CntW       = 16,
  parameter int unsigned MemTimeout = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rs1_d_i,
  input  logic [4:0]      rs2_d_i,
  input  logic [4:0]      rs1_e_i,
  input  logic [4:0]      rs2_e_i,
  input  logic [4:0]      rd_e_i,
  input  logic            mem_read_e_i,
  input  logic            pc_src_e_i,
  input  logic [4:0]      rd_m_i,
  input  logic [4:0]      rd_w_i,
  input  logic            reg_write_m_i,
  input  logic            reg_write_w_i,
  input  logic            mem_req_m_i,
  input  logic            mem_ack_m_i,
  output logic            stall_f_o,
  output logic            stall_d_o,
  output logic            stall_e_o,
  output logic            stall_m_o,
  output logic            flush_d_o,
  output logic            flush_e_o,
  output logic            flush_w_o,
  output logic [1:0]      forward_ae_o,
  output logic [1:0]      forward_be_o,
  output logic            mem_err_o,
  output logic [CntW-1:0] stall_count_o,
  output logic [CntW-1:0] flush_count_o
);

  // Wait counter is at least 8 bits and always wide enough to hold MemTimeout.
  localparam int unsigned WaitNeed = $clog2(MemTimeout + 1);
  localparam int unsigned WaitW    = (WaitNeed > 8) ? WaitNeed : 8;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MemTimeout - 1);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StError
  } state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             mem_err_q;
  logic [CntW-1:0]  stall_count_q, stall_count_d;
  logic [CntW-1:0]  flush_count_q, flush_count_d;

  logic memstall;
  logic loaduse;
  logic stall_win;
  logic flush_win;

  // Hazard detection terms; an errored memory keeps the pipeline frozen for good.
  always_comb begin
    memstall = (state_q == StError) ? 1'b1 : (mem_req_m_i && !mem_ack_m_i);
    loaduse  = mem_read_e_i && (rd_e_i != 5'd0) &&
               ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
  end

  // Prioritised stall/flush generation: reset, memory stall, redirect, load-use.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_w_o = 1'b0;
    stall_win = 1'b0;
    flush_win = 1'b0;
    if (rst_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (memstall) begin
      // Execute is held, so a pending redirect or load-use resolves after release.
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      flush_w_o = 1'b1;
      stall_win = 1'b1;
    end else if (pc_src_e_i) begin
      // Decode holds a wrong-path instruction, so no load-use stall is needed.
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_win = 1'b1;
    end else if (loaduse) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
      stall_win = 1'b1;
    end
  end

  // Operand forwarding into Execute; the younger Memory result beats Writeback.
  always_comb begin
    forward_ae_o = 2'b00;
    forward_be_o = 2'b00;
    if (!rst_i) begin
      if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs1_e_i)) begin
        forward_ae_o = 2'b10;
      end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs1_e_i)) begin
        forward_ae_o = 2'b01;
      end
      if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs2_e_i)) begin
        forward_be_o = 2'b10;
      end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs2_e_i)) begin
        forward_be_o = 2'b01;
      end
    end
  end

  // Memory wait FSM with timeout detection and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (memstall) begin
            state_q    <= StMemWait;
            wait_cnt_q <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (mem_ack_m_i || !mem_req_m_i) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WaitLimit) begin
            state_q   <= StError;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StError: begin
          state_q <= StError;
        end
        default: begin
          state_q    <= StRun;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Saturating increments for the performance counters.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_win && (stall_count_q != {CntW{1'b1}})) begin
      stall_count_d = stall_count_q + CntW'(1);
    end
    if (flush_win && (flush_count_q != {CntW{1'b1}})) begin
      flush_count_d = flush_count_q + CntW'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mem_err_o     = mem_err_q;
  assign stall_count_o = stall_count_q;
  assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (CntW=4, MemTimeout=4).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       mem_read_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ack_m;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .CntW       (4),
    .MemTimeout (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rs1_d_i       (rs1_d),
    .rs2_d_i       (rs2_d),
    .rs1_e_i       (rs1_e),
    .rs2_e_i       (rs2_e),
    .rd_e_i        (rd_e),
    .mem_read_e_i  (mem_read_e),
    .pc_src_e_i    (pc_src_e),
    .rd_m_i        (rd_m),
    .rd_w_i        (rd_w),
    .reg_write_m_i (reg_write_m),
    .reg_write_w_i (reg_write_w),
    .mem_req_m_i   (mem_req_m),
    .mem_ack_m_i   (mem_ack_m),
    .stall_f_o     (stall_f),
    .stall_d_o     (stall_d),
    .stall_e_o     (stall_e),
    .stall_m_o     (stall_m),
    .flush_d_o     (flush_d),
    .flush_e_o     (flush_e),
    .flush_w_o     (flush_w),
    .forward_ae_o  (fwd_a),
    .forward_be_o  (fwd_b),
    .mem_err_o     (mem_err),
    .stall_count_o (stall_cnt),
    .flush_count_o (flush_cnt)
  );

  // Control word packs {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}.
  function automatic logic [6:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  endfunction

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    mem_read_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_req_m = 0; mem_ack_m = 0;
  endtask

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    rd_m = 7; rs1_e = 7; reg_write_m = 1; mem_req_m = 1;
    #1;
    checks++;
    if (ctl() !== 7'b0000111) begin
      errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 7'b0000111);
    end
    checks++;
    if (fwd_a !== 2'b00) begin
      errors++; $display("FAIL reset_fwd got=%b exp=00", fwd_a);
    end
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if ({mem_err, stall_cnt, flush_cnt} !== 9'd0) begin
      errors++; $display("FAIL reset_regs got err=%b sc=%0d fc=%0d exp 0", mem_err, stall_cnt,
                         flush_cnt);
    end
    checks++;
    if (ctl() !== 7'b0) begin
      errors++; $display("FAIL idle_ctl got=%b exp=0000000", ctl());
    end
  endtask

  task automatic test_load_use();
    do_reset();
    mem_read_e = 1; rd_e = 5; rs1_d = 5;
    #1;
    checks++;
    if (ctl() !== 7'b1100010) begin
      errors++; $display("FAIL loaduse_ctl got=%b exp=1100010", ctl());
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cnt !== 4'd1 || ctl() !== 7'b0) begin
      errors++; $display("FAIL loaduse_cnt got sc=%0d ctl=%b exp sc=1 ctl=0", stall_cnt, ctl());
    end
    // Match on rs2 also triggers.
    mem_read_e = 1; rd_e = 9; rs2_d = 9;
    #1;
    checks++;
    if (stall_f !== 1'b1) begin
      errors++; $display("FAIL loaduse_rs2 got=%b exp=1", stall_f);
    end
    idle();
    mem_read_e = 1; rd_e = 0; rs1_d = 0;
    #1;
    checks++;
    if (ctl() !== 7'b0) begin
      errors++; $display("FAIL loaduse_x0 got=%b exp=0000000", ctl());
    end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++; $display("FAIL loaduse_x0_cnt got=%0d exp=1", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    pc_src_e = 1; mem_read_e = 1; rd_e = 5; rs1_d = 5;
    #1;
    checks++;
    if (ctl() !== 7'b0000110) begin
      errors++; $display("FAIL branch_ctl got=%b exp=0000110", ctl());
    end
    tick();
    idle();
    #1;
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL branch_cnt got fc=%0d sc=%0d exp fc=1 sc=0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_forward();
    do_reset();
    rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 7; reg_write_m = 1; reg_write_w = 1;
    #1;
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      errors++; $display("FAIL fwd_mem got a=%b b=%b exp 10 10", fwd_a, fwd_b);
    end
    reg_write_m = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      errors++; $display("FAIL fwd_wb got a=%b b=%b exp 01 01", fwd_a, fwd_b);
    end
    rd_w = 0; rs1_e = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b00) begin
      errors++; $display("FAIL fwd_x0 got=%b exp=00", fwd_a);
    end
    // Split sources: A from Memory, B from Writeback, during a memory stall.
    rd_m = 3; rd_w = 4; rs1_e = 3; rs2_e = 4; reg_write_m = 1; reg_write_w = 1;
    mem_req_m = 1;
    #1;
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
      errors++; $display("FAIL fwd_split got a=%b b=%b exp 10 01", fwd_a, fwd_b);
    end
    idle();
  endtask

  task automatic test_mem_latency();
    do_reset();
    mem_req_m = 1; pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl() !== 7'b1111001) begin
        errors++; $display("FAIL memwait_ctl cyc=%0d got=%b exp=1111001", i, ctl());
      end
      tick();
    end
    pc_src_e = 0; mem_ack_m = 1;
    #1;
    checks++;
    if (ctl() !== 7'b0) begin
      errors++; $display("FAIL memack_ctl got=%b exp=0000000", ctl());
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL memwait_cnt got sc=%0d fc=%0d err=%b exp 3 0 0", stall_cnt,
                         flush_cnt, mem_err);
    end
    mem_req_m = 1; mem_ack_m = 1;
    #1;
    checks++;
    if (ctl() !== 7'b0) begin
      errors++; $display("FAIL memfast_ctl got=%b exp=0000000", ctl());
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++; $display("FAIL memfast_cnt got=%0d exp=3", stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_m = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mem_err !== 1'b0) begin
        errors++; $display("FAIL timeout_early cyc=%0d got=%b exp=0", i, mem_err);
      end
      tick();
    end
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err got=%b exp=1", mem_err);
    end
    mem_ack_m = 1;
    #1;
    checks++;
    if (ctl() !== 7'b1111001) begin
      errors++; $display("FAIL error_hold_ack got=%b exp=1111001", ctl());
    end
    tick();
    idle();
    #1;
    checks++;
    if (ctl() !== 7'b1111001 || mem_err !== 1'b1 || stall_cnt !== 4'd5) begin
      errors++; $display("FAIL error_sticky got ctl=%b err=%b sc=%0d exp 1111001 1 5", ctl(),
                         mem_err, stall_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b0000111) begin
      errors++; $display("FAIL error_rst_ctl got=%b exp=0000111", ctl());
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ctl() !== 7'b0 || mem_err !== 1'b0 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL error_cleared got ctl=%b err=%b sc=%0d exp 0 0 0", ctl(), mem_err,
                         stall_cnt);
    end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    mem_req_m = 1;
    for (int i = 0; i < 3; i++) tick();
    mem_ack_m = 1;
    #1;
    checks++;
    if (stall_f !== 1'b0) begin
      errors++; $display("FAIL limit_ack_ctl got=%b exp=0", stall_f);
    end
    tick();
    idle();
    #1;
    checks++;
    if (mem_err !== 1'b0 || stall_f !== 1'b0 || stall_cnt !== 4'd3) begin
      errors++; $display("FAIL limit_ack got err=%b stf=%b sc=%0d exp 0 0 3", mem_err, stall_f,
                         stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_read_e = 1; rd_e = 12; rs2_d = 12;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_reach got=%0d exp=15", stall_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt);
    end
    idle();
    pc_src_e = 1;
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if (flush_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_flush got=%0d exp=15", flush_cnt);
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_branch();
    test_forward();
    test_mem_latency();
    test_timeout();
    test_ack_at_limit();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
